// File: rtl/chess_game_pkg.sv
// Shared definitions for the timed chess game: FSM state encoding and
// player encoding (the board-layout matrix uses the same player values).
package chess_game_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RUN_WHITE = 3'd1;
  localparam logic [2:0] RUN_BLACK = 3'd2;
  localparam logic [2:0] PAUSED    = 3'd3;
  localparam logic [2:0] GAME_OVER = 3'd4;

  localparam logic WHITE_PLAYER = 1'b1;
  localparam logic BLACK_PLAYER = 1'b0;

  // Running state that belongs to a given player.
  function automatic logic [2:0] runStateFor(input logic player);
    return (player == WHITE_PLAYER) ? RUN_WHITE : RUN_BLACK;
  endfunction

endpackage

// File: rtl/chess_turn_scheduler_if.sv
// Game-control bus between the board side (master) and the turn scheduler (slave).
interface chess_turn_scheduler_if #(
  parameter int TIME_WIDTH = 10
);

  logic                  StartGame;
  logic                  PauseSwitch;
  logic                  MoveCommit;
  logic                  KingCaptured;
  logic                  ActivePlayer;
  logic                  BoardEnable;
  logic [TIME_WIDTH-1:0] WhiteSeconds;
  logic [TIME_WIDTH-1:0] BlackSeconds;
  logic [2:0]            GameState;
  logic                  GameOver;
  logic                  Winner;
  logic                  Timeout;

  modport master (
    output StartGame, PauseSwitch, MoveCommit, KingCaptured,
    input  ActivePlayer, BoardEnable, WhiteSeconds, BlackSeconds,
           GameState, GameOver, Winner, Timeout
  );

  modport slave (
    input  StartGame, PauseSwitch, MoveCommit, KingCaptured,
    output ActivePlayer, BoardEnable, WhiteSeconds, BlackSeconds,
           GameState, GameOver, Winner, Timeout
  );

endinterface

// File: rtl/player_countdown.sv
// One player's remaining-time counter: reloads to the starting time,
// adds the per-move increment with saturation and counts down without underflow.
module player_countdown #(
  parameter int TIME_WIDTH        = 10,
  parameter int INITIAL_SECONDS   = 300,
  parameter int INCREMENT_SECONDS = 0
) (
  input  logic                  OutClock,
  input  logic                  resetApp,
  input  logic                  load,
  input  logic                  decrement,
  input  logic                  add_increment,
  output logic [TIME_WIDTH-1:0] seconds,
  output logic                  one_left
);

  localparam logic [TIME_WIDTH-1:0] INIT_VALUE = TIME_WIDTH'(INITIAL_SECONDS);
  localparam logic [TIME_WIDTH:0]   SAT_LIMIT  = {1'b0, {TIME_WIDTH{1'b1}}};

  logic [TIME_WIDTH-1:0] nextSeconds;
  logic [TIME_WIDTH:0]   sumSeconds;

  // The next decrement empties the clock (one second left, or already zero).
  assign one_left = (seconds <= TIME_WIDTH'(1));

  // Next counter value: load, then saturating increment, then guarded decrement.
  always_comb begin
    nextSeconds = seconds;
    sumSeconds  = {1'b0, seconds} + (TIME_WIDTH+1)'(INCREMENT_SECONDS);
    if (load) begin
      nextSeconds = INIT_VALUE;
    end else if (add_increment) begin
      if (sumSeconds > SAT_LIMIT) begin
        nextSeconds = {TIME_WIDTH{1'b1}};
      end else begin
        nextSeconds = sumSeconds[TIME_WIDTH-1:0];
      end
    end else if (decrement) begin
      if (seconds != {TIME_WIDTH{1'b0}}) begin
        nextSeconds = seconds - TIME_WIDTH'(1);
      end else begin
        nextSeconds = seconds;
      end
    end else begin
      nextSeconds = seconds;
    end
  end

  // Counter register, restored to the starting time on reset.
  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      seconds <= INIT_VALUE;
    end else begin
      seconds <= nextSeconds;
    end
  end

endmodule

// File: rtl/chess_turn_scheduler.sv
// Turn scheduler and game clock: decides who may move, runs the per-player
// countdowns and ends the game on timeout or king capture.
module chess_turn_scheduler
  import chess_game_pkg::*;
#(
  parameter int TICKS_PER_SECOND  = 10,
  parameter int INITIAL_SECONDS   = 300,
  parameter int INCREMENT_SECONDS = 0,
  parameter int TIME_WIDTH        = 10
) (
  input logic                   OutClock,
  input logic                   resetApp,
  chess_turn_scheduler_if.slave gameBus
);

  localparam int TICK_W = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SECOND - 1);

  logic [2:0]            gameState, nextState;
  logic [TICK_W-1:0]     tickCount, nextTick;
  logic                  savedPlayer, nextSaved;
  logic                  activePlayer, nextActive;
  logic                  boardEnable, gameOver;
  logic                  winner, nextWinner;
  logic                  timeoutFlag, nextTimeout;

  logic                  runningPlayer, runningOneLeft, tickWrap;
  logic                  decRunning, incRunning, loadClocks;
  logic                  whiteOneLeft, blackOneLeft;
  logic [TIME_WIDTH-1:0] whiteSeconds, blackSeconds;

  assign runningPlayer  = (gameState == RUN_WHITE) ? WHITE_PLAYER : BLACK_PLAYER;
  assign runningOneLeft = (runningPlayer == WHITE_PLAYER) ? whiteOneLeft : blackOneLeft;
  assign tickWrap       = (tickCount == TICK_LAST);

  player_countdown #(
    .TIME_WIDTH(TIME_WIDTH), .INITIAL_SECONDS(INITIAL_SECONDS),
    .INCREMENT_SECONDS(INCREMENT_SECONDS)
  ) whiteClock (
    .OutClock(OutClock), .resetApp(resetApp), .load(loadClocks),
    .decrement(decRunning & (runningPlayer == WHITE_PLAYER)),
    .add_increment(incRunning & (runningPlayer == WHITE_PLAYER)),
    .seconds(whiteSeconds), .one_left(whiteOneLeft)
  );

  player_countdown #(
    .TIME_WIDTH(TIME_WIDTH), .INITIAL_SECONDS(INITIAL_SECONDS),
    .INCREMENT_SECONDS(INCREMENT_SECONDS)
  ) blackClock (
    .OutClock(OutClock), .resetApp(resetApp), .load(loadClocks),
    .decrement(decRunning & (runningPlayer == BLACK_PLAYER)),
    .add_increment(incRunning & (runningPlayer == BLACK_PLAYER)),
    .seconds(blackSeconds), .one_left(blackOneLeft)
  );

  // Game FSM: a move outranks a pause request, which outranks the second tick.
  always_comb begin
    nextState   = gameState;
    nextTick    = tickCount;
    nextSaved   = savedPlayer;
    nextWinner  = winner;
    nextTimeout = timeoutFlag;
    decRunning  = 1'b0;
    incRunning  = 1'b0;
    loadClocks  = 1'b0;
    case (gameState)
      IDLE: begin
        loadClocks = 1'b1;
        if (gameBus.StartGame) begin
          nextState = RUN_WHITE;
          nextTick  = {TICK_W{1'b0}};
        end else begin
          nextState = IDLE;
        end
      end
      RUN_WHITE, RUN_BLACK: begin
        if (gameBus.MoveCommit) begin
          if (gameBus.KingCaptured) begin
            nextState   = GAME_OVER;
            nextWinner  = runningPlayer;
            nextTimeout = 1'b0;
          end else begin
            incRunning = 1'b1;
            nextState  = runStateFor(~runningPlayer);
            nextTick   = {TICK_W{1'b0}};
          end
        end else if (gameBus.PauseSwitch) begin
          nextSaved = runningPlayer;
          nextState = PAUSED;
        end else if (tickWrap) begin
          nextTick   = {TICK_W{1'b0}};
          decRunning = 1'b1;
          if (runningOneLeft) begin
            nextState   = GAME_OVER;
            nextWinner  = ~runningPlayer;
            nextTimeout = 1'b1;
          end else begin
            nextState = gameState;
          end
        end else begin
          nextTick = tickCount + TICK_W'(1);
        end
      end
      PAUSED: begin
        if (!gameBus.PauseSwitch) begin
          nextState = runStateFor(savedPlayer);
        end else begin
          nextState = PAUSED;
        end
      end
      GAME_OVER: begin
        nextState = GAME_OVER;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Turn indicator follows the running state and holds while paused or over.
  always_comb begin
    if (nextState == RUN_WHITE) begin
      nextActive = WHITE_PLAYER;
    end else if (nextState == RUN_BLACK) begin
      nextActive = BLACK_PLAYER;
    end else begin
      nextActive = activePlayer;
    end
  end

  // State and registered outputs, all updated on the same edge.
  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      gameState    <= IDLE;
      tickCount    <= {TICK_W{1'b0}};
      savedPlayer  <= WHITE_PLAYER;
      activePlayer <= WHITE_PLAYER;
      boardEnable  <= 1'b0;
      gameOver     <= 1'b0;
      winner       <= 1'b0;
      timeoutFlag  <= 1'b0;
    end else begin
      gameState    <= nextState;
      tickCount    <= nextTick;
      savedPlayer  <= nextSaved;
      activePlayer <= nextActive;
      boardEnable  <= (nextState == RUN_WHITE) || (nextState == RUN_BLACK);
      gameOver     <= (nextState == GAME_OVER);
      winner       <= nextWinner;
      timeoutFlag  <= nextTimeout;
    end
  end

  assign gameBus.ActivePlayer = activePlayer;
  assign gameBus.BoardEnable  = boardEnable;
  assign gameBus.WhiteSeconds = whiteSeconds;
  assign gameBus.BlackSeconds = blackSeconds;
  assign gameBus.GameState    = gameState;
  assign gameBus.GameOver     = gameOver;
  assign gameBus.Winner       = winner;
  assign gameBus.Timeout      = timeoutFlag;

endmodule

// File: tb/tb_chess_turn_scheduler.sv
// Bench for chess_turn_scheduler: directed vector table, hand-written corner
// sequences and randomized play against a behavioural game model.
module tb_chess_turn_scheduler;

  localparam int TPS  = 2;
  localparam int INIT = 3;
  localparam int INC  = 1;
  localparam int TW   = 4;
  localparam int MAXS = 15;

  localparam int P_IDLE = 0, P_RUN = 1, P_PAUSED = 2, P_OVER = 3;

  typedef struct packed {
    logic       ap;
    logic       be;
    logic [3:0] w;
    logic [3:0] b;
    logic [2:0] st;
    logic       go;
    logic       wn;
    logic       to;
  } expT;

  typedef struct {
    logic start;
    logic pause;
    logic move;
    logic king;
    expT  exp;
  } vecT;

  logic OutClock = 1'b0;
  logic resetApp = 1'b0;
  int   tests = 0;
  int   fails = 0;

  chess_turn_scheduler_if #(.TIME_WIDTH(TW)) gameBus ();

  chess_turn_scheduler #(
    .TICKS_PER_SECOND(TPS), .INITIAL_SECONDS(INIT),
    .INCREMENT_SECONDS(INC), .TIME_WIDTH(TW)
  ) dut (
    .OutClock(OutClock),
    .resetApp(resetApp),
    .gameBus(gameBus)
  );

  always #5 OutClock = ~OutClock;

  // behavioural model of the game
  int   mPhase;
  logic mTurn, mSaved, mWinner, mTimeout;
  int   mTick;
  int   mSec [2];

  function automatic expT e(input logic ap, input logic be, input int w, input int b,
                            input int st, input logic go, input logic wn, input logic to);
    expT r;
    r.ap = ap; r.be = be; r.w = 4'(w); r.b = 4'(b); r.st = 3'(st);
    r.go = go; r.wn = wn; r.to = to;
    return r;
  endfunction

  function automatic vecT mkVec(input logic s, input logic p, input logic m,
                                input logic k, input expT x);
    vecT v;
    v.start = s; v.pause = p; v.move = m; v.king = k; v.exp = x;
    return v;
  endfunction

  task automatic modelReset();
    mPhase = P_IDLE; mTurn = 1'b1; mSaved = 1'b1; mWinner = 1'b0; mTimeout = 1'b0;
    mTick = 0; mSec[0] = INIT; mSec[1] = INIT;
  endtask

  task automatic modelStep(input logic s, input logic p, input logic m, input logic k);
    case (mPhase)
      P_IDLE: if (s) begin mPhase = P_RUN; mTurn = 1'b1; mTick = 0; end
      P_RUN: begin
        if (m) begin
          if (k) begin
            mPhase = P_OVER; mWinner = mTurn; mTimeout = 1'b0;
          end else begin
            mSec[mTurn] = (mSec[mTurn] + INC > MAXS) ? MAXS : mSec[mTurn] + INC;
            mTurn = ~mTurn; mTick = 0;
          end
        end else if (p) begin
          mSaved = mTurn; mPhase = P_PAUSED;
        end else begin
          mTick++;
          if (mTick == TPS) begin
            mTick = 0;
            if (mSec[mTurn] > 0) mSec[mTurn]--;
            if (mSec[mTurn] == 0) begin
              mPhase = P_OVER; mWinner = ~mTurn; mTimeout = 1'b1;
            end
          end
        end
      end
      P_PAUSED: if (!p) begin mPhase = P_RUN; mTurn = mSaved; end
      default: ;
    endcase
  endtask

  function automatic expT modelExp();
    int st;
    case (mPhase)
      P_IDLE:   st = 0;
      P_RUN:    st = mTurn ? 1 : 2;
      P_PAUSED: st = 3;
      default:  st = 4;
    endcase
    return e(mTurn, mPhase == P_RUN, mSec[1], mSec[0], st, mPhase == P_OVER,
             mWinner, mTimeout);
  endfunction

  task automatic check(input string name, input expT x);
    expT got;
    got = {gameBus.ActivePlayer, gameBus.BoardEnable, gameBus.WhiteSeconds,
           gameBus.BlackSeconds, gameBus.GameState, gameBus.GameOver,
           gameBus.Winner, gameBus.Timeout};
    tests++;
    if (got !== x) begin
      fails++;
      $display("FAIL %s: got ap=%b be=%b w=%0d b=%0d st=%0d go=%b wn=%b to=%b, want ap=%b be=%b w=%0d b=%0d st=%0d go=%b wn=%b to=%b",
               name, got.ap, got.be, got.w, got.b, got.st, got.go, got.wn, got.to,
               x.ap, x.be, x.w, x.b, x.st, x.go, x.wn, x.to);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic m, input logic k);
    gameBus.StartGame = s; gameBus.PauseSwitch = p;
    gameBus.MoveCommit = m; gameBus.KingCaptured = k;
    @(posedge OutClock);
    #1;
  endtask

  task automatic doReset();
    gameBus.StartGame = 1'b0; gameBus.PauseSwitch = 1'b0;
    gameBus.MoveCommit = 1'b0; gameBus.KingCaptured = 1'b0;
    resetApp = 1'b1;
    @(posedge OutClock);
    #1;
    check("reset", e(1, 0, 3, 3, 0, 0, 0, 0));
    resetApp = 1'b0;
  endtask

  vecT vecs [12];

  initial begin
    logic s, p, m, k, pauseLvl;

    // start, white second, handover, black timeout, terminal GAME_OVER
    vecs[0]  = mkVec(1, 0, 0, 0, e(1, 1, 3, 3, 1, 0, 0, 0));
    vecs[1]  = mkVec(0, 0, 0, 0, e(1, 1, 3, 3, 1, 0, 0, 0));
    vecs[2]  = mkVec(0, 0, 0, 0, e(1, 1, 2, 3, 1, 0, 0, 0));
    vecs[3]  = mkVec(0, 0, 1, 0, e(0, 1, 3, 3, 2, 0, 0, 0));
    vecs[4]  = mkVec(0, 0, 0, 0, e(0, 1, 3, 3, 2, 0, 0, 0));
    vecs[5]  = mkVec(0, 0, 0, 0, e(0, 1, 3, 2, 2, 0, 0, 0));
    vecs[6]  = mkVec(0, 0, 0, 0, e(0, 1, 3, 2, 2, 0, 0, 0));
    vecs[7]  = mkVec(0, 0, 0, 0, e(0, 1, 3, 1, 2, 0, 0, 0));
    vecs[8]  = mkVec(0, 0, 0, 0, e(0, 1, 3, 1, 2, 0, 0, 0));
    vecs[9]  = mkVec(0, 0, 0, 0, e(0, 0, 3, 0, 4, 1, 1, 1));
    vecs[10] = mkVec(1, 0, 1, 1, e(0, 0, 3, 0, 4, 1, 1, 1));
    vecs[11] = mkVec(1, 1, 0, 0, e(0, 0, 3, 0, 4, 1, 1, 1));

    doReset();
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].start, vecs[i].pause, vecs[i].move, vecs[i].king);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // move on the expiring wrap cycle wins over the timeout
    doReset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("white_at_one", e(1, 1, 1, 3, 1, 0, 0, 0));
    step(0, 0, 1, 0);
    check("move_beats_wrap", e(0, 1, 2, 3, 2, 0, 0, 0));

    // pause for 7 cycles in RUN_BLACK with tick mid-second, then resume
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("pause_enter", e(0, 0, 2, 3, 3, 0, 0, 0));
    for (int i = 0; i < 6; i++) step(0, 1, i == 2, 0);
    check("pause_hold", e(0, 0, 2, 3, 3, 0, 0, 0));
    step(0, 0, 0, 0);
    check("pause_release", e(0, 1, 2, 3, 2, 0, 0, 0));
    step(0, 0, 0, 0);
    check("tick_resumed", e(0, 1, 2, 2, 2, 0, 0, 0));

    // move together with pause: move first, then pause with the other player saved
    step(0, 1, 1, 0);
    check("move_with_pause", e(1, 1, 2, 3, 1, 0, 0, 0));
    step(0, 1, 0, 0);
    check("pause_after_move", e(1, 0, 2, 3, 3, 0, 0, 0));
    step(0, 0, 0, 0);
    check("resume_white", e(1, 1, 2, 3, 1, 0, 0, 0));

    // king capture by black, then GAME_OVER ignores everything
    step(0, 0, 1, 0);
    check("to_black", e(0, 1, 3, 3, 2, 0, 0, 0));
    step(0, 0, 1, 1);
    check("king_captured", e(0, 0, 3, 3, 4, 1, 0, 0));
    step(1, 0, 1, 0);
    check("over_terminal", e(0, 0, 3, 3, 4, 1, 0, 0));

    // asynchronous reset in the middle of a game
    doReset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("pre_async_reset", e(1, 1, 2, 3, 1, 0, 0, 0));
    resetApp = 1'b1;
    #1;
    check("async_reset", e(1, 0, 3, 3, 0, 0, 0, 0));
    resetApp = 1'b0;

    // increment saturates at the counter maximum
    step(1, 0, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 0, 1, 0);
    check("sat_reach", e(1, 1, 15, 15, 1, 0, 0, 0));
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("sat_hold", e(1, 1, 15, 15, 1, 0, 0, 0));

    // randomized play against the model
    doReset();
    modelReset();
    pauseLvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ((mPhase == P_OVER && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
        resetApp = 1'b1;
        modelReset();
        #1;
        check("rand_reset", modelExp());
        resetApp = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0) pauseLvl = ~pauseLvl;
        s = 1'($urandom_range(0, 1));
        p = pauseLvl;
        m = ($urandom_range(0, 2) == 0);
        k = m && ($urandom_range(0, 11) == 0);
        modelStep(s, p, m, k);
        step(s, p, m, k);
        check("random", modelExp());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
